// File: rtl/i2c_target_regfile_if.sv
// Bus bundle between the I2C target register file and its environment:
// raw I2C pins, host preload port and the write report back to the host.
interface i2c_target_regfile_if #(
  parameter int PTR_W = 4
);
  logic             scl;
  logic             sda_in;
  logic             sda_drive_low;
  logic             host_we;
  logic [PTR_W-1:0] host_addr;
  logic [7:0]       host_wdata;
  logic             wr_strobe;
  logic [PTR_W-1:0] wr_addr;
  logic [7:0]       wr_data;
  logic             busy;

  modport master (
    output scl, sda_in, host_we, host_addr, host_wdata,
    input  sda_drive_low, wr_strobe, wr_addr, wr_data, busy
  );

  modport slave (
    input  scl, sda_in, host_we, host_addr, host_wdata,
    output sda_drive_low, wr_strobe, wr_addr, wr_data, busy
  );
endinterface

// File: rtl/i2c_target_regfile.sv
// I2C target emulating the colour sensor: 8-bit register file with auto-incrementing
// pointer, host preload port and a report of every byte the master writes.
//
// state      | meaning
// IDLE       | bus free, waiting for START
// DEV_ADDR   | shifting in device address + R/W
// DEV_ACK    | driving ACK for our address
// REG_ADDR   | shifting in register pointer
// REG_ACK    | driving ACK for the pointer byte
// WDATA      | shifting in a data byte to write
// WDATA_ACK  | driving ACK for a written byte
// RDATA      | driving a register byte out, MSB first
// RDATA_MACK | SDA released, sampling master ACK/NACK
// IGNORE     | not addressed or NACKed; wait for START/STOP
module i2c_target_regfile #(
  parameter logic [6:0] DEVICE_ADDRESS = 7'h44,
  parameter int         NUM_REGS       = 16,
  parameter int         PTR_W          = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  i2c_target_regfile_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, DEV_ADDR, DEV_ACK, REG_ADDR, REG_ACK,
    WDATA, WDATA_ACK, RDATA, RDATA_MACK, IGNORE
  } state_t;

  state_t           state;
  logic [1:0]       scl_sync;
  logic [1:0]       sda_sync;
  logic             scl_d;
  logic             sda_d;
  logic [3:0]       bit_cnt;
  logic [7:0]       shreg;
  logic [7:0]       tx;
  logic             rw;
  logic             mack;
  logic [PTR_W-1:0] ptr;
  logic [7:0]       regs [NUM_REGS];

  logic       scl_s;
  logic       sda_s;
  logic       scl_rise;
  logic       scl_fall;
  logic       start_det;
  logic       stop_det;
  logic [7:0] rx_byte;

  assign scl_s     = scl_sync[1];
  assign sda_s     = sda_sync[1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
  assign rx_byte   = {shreg[6:0], sda_s};

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      // synchronizers reset to the idle-bus level so release never looks like an edge
      scl_sync          <= 2'b11;
      sda_sync          <= 2'b11;
      scl_d             <= 1'b1;
      sda_d             <= 1'b1;
      state             <= IDLE;
      bit_cnt           <= 4'd0;
      shreg             <= 8'h00;
      tx                <= 8'h00;
      rw                <= 1'b0;
      mack              <= 1'b0;
      ptr               <= '0;
      bus.sda_drive_low <= 1'b0;
      bus.wr_strobe     <= 1'b0;
      bus.wr_addr       <= '0;
      bus.wr_data       <= 8'h00;
      bus.busy          <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
    end else begin
      scl_sync      <= {scl_sync[0], bus.scl};
      sda_sync      <= {sda_sync[0], bus.sda_in};
      scl_d         <= scl_s;
      sda_d         <= sda_s;
      bus.wr_strobe <= 1'b0;

      // host write first so a same-cycle I2C write to the same register overrides it
      if (bus.host_we) regs[bus.host_addr] <= bus.host_wdata;

      if (start_det) begin
        state             <= DEV_ADDR;
        bit_cnt           <= 4'd0;
        bus.busy          <= 1'b1;
        bus.sda_drive_low <= 1'b0;
      end else if (stop_det) begin
        state             <= IDLE;
        bus.busy          <= 1'b0;
        bus.sda_drive_low <= 1'b0;
      end else begin
        if (scl_rise && (state == DEV_ADDR || state == REG_ADDR || state == WDATA)) begin
          shreg   <= rx_byte;
          bit_cnt <= bit_cnt + 4'd1;
        end
        case (state)
          DEV_ADDR: if (scl_rise && bit_cnt == 4'd7) begin
            bit_cnt <= 4'd0;
            if (rx_byte[7:1] == DEVICE_ADDRESS) begin
              rw    <= rx_byte[0];
              state <= DEV_ACK;
            end else begin
              state <= IGNORE;
            end
          end
          REG_ADDR: if (scl_rise && bit_cnt == 4'd7) begin
            bit_cnt <= 4'd0;
            ptr     <= rx_byte[PTR_W-1:0];
            state   <= REG_ACK;
          end
          WDATA: if (scl_rise && bit_cnt == 4'd7) begin
            bit_cnt       <= 4'd0;
            regs[ptr]     <= rx_byte;
            bus.wr_strobe <= 1'b1;
            bus.wr_addr   <= ptr;
            bus.wr_data   <= rx_byte;
            ptr           <= ptr + 1'b1;
            state         <= WDATA_ACK;
          end
          // first falling edge asserts ACK, the next one ends it
          DEV_ACK, REG_ACK, WDATA_ACK: if (scl_fall) begin
            if (!bus.sda_drive_low) begin
              bus.sda_drive_low <= 1'b1;
            end else begin
              bus.sda_drive_low <= 1'b0;
              bit_cnt           <= 4'd0;
              if (state != DEV_ACK) begin
                state <= WDATA;
              end else if (rw) begin
                tx                <= regs[ptr];
                bus.sda_drive_low <= ~regs[ptr][7];
                state             <= RDATA;
              end else begin
                state <= REG_ADDR;
              end
            end
          end
          RDATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                bus.sda_drive_low <= 1'b0;
                ptr               <= ptr + 1'b1;
                mack              <= 1'b0;
                state             <= RDATA_MACK;
              end else begin
                tx                <= {tx[6:0], 1'b0};
                bus.sda_drive_low <= ~tx[6];
              end
            end
          end
          RDATA_MACK: begin
            if (scl_rise) begin
              if (sda_s) state <= IGNORE;
              else       mack  <= 1'b1;
            end else if (scl_fall && mack) begin
              tx                <= regs[ptr];
              bus.sda_drive_low <= ~regs[ptr][7];
              bit_cnt           <= 4'd0;
              state             <= RDATA;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Bench for i2c_target_regfile: bit-banged I2C master plus an array/pointer model
// of the register file, directed cases followed by randomized transactions.
module tb_i2c_target_regfile;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic sda_m;
  always #20 clock = ~clock;

  i2c_target_regfile_if #(.PTR_W(4)) bus ();
  assign bus.sda_in = sda_m & ~bus.sda_drive_low;

  i2c_target_regfile #(.DEVICE_ADDRESS(7'h44), .NUM_REGS(16), .PTR_W(4)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [7:0]  m_regs [16];
  int          m_ptr;
  logic [11:0] obs_q[$];
  logic [11:0] exp_q[$];
  int          drive_cycles = 0;
  logic [7:0]  wbuf [8];
  logic        col_en;
  logic [3:0]  col_addr;
  logic [7:0]  col_data;

  always @(negedge clock) begin
    if (bus.wr_strobe) obs_q.push_back({bus.wr_addr, bus.wr_data});
    if (bus.sda_drive_low) drive_cycles++;
  end

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clk(int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic host_write(logic [3:0] a, logic [7:0] d);
    bus.host_we = 1'b1; bus.host_addr = a; bus.host_wdata = d;
    clk(1);
    bus.host_we = 1'b0;
    m_regs[a] = d;
  endtask

  task automatic i2c_start();
    sda_m = 1'b0; clk(10); bus.scl = 1'b0; clk(5);
  endtask

  task automatic i2c_restart();
    sda_m = 1'b1; clk(5); bus.scl = 1'b1; clk(10); sda_m = 1'b0; clk(10); bus.scl = 1'b0; clk(5);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; clk(5); bus.scl = 1'b1; clk(10); sda_m = 1'b1; clk(10);
  endtask

  task automatic write_bit(logic b);
    sda_m = b; clk(5); bus.scl = 1'b1; clk(10); bus.scl = 1'b0; clk(5);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; clk(5); bus.scl = 1'b1; clk(5); b = bus.sda_in; clk(5); bus.scl = 1'b0; clk(5);
  endtask

  // exp_line: level the master should see in the ack slot (0 = ACK)
  task automatic write_byte(logic [7:0] b, logic exp_line, string tag);
    logic a;
    for (int i = 7; i >= 0; i--) begin
      if (i == 0 && col_en) begin
        // host strobe lands on the same clock as the register write (3 clocks after SCL rises)
        sda_m = b[0]; clk(5); bus.scl = 1'b1; clk(2);
        bus.host_we = 1'b1; bus.host_addr = col_addr; bus.host_wdata = col_data;
        clk(1);
        bus.host_we = 1'b0;
        check({tag, " strobe_latency"}, 32'(bus.wr_strobe), 32'd1);
        clk(7); bus.scl = 1'b0; clk(5);
      end else begin
        write_bit(b[i]);
      end
    end
    read_bit(a);
    check({tag, " ack"}, 32'(a), 32'(exp_line));
  endtask

  task automatic read_byte(output logic [7:0] b, input int hw_bit, input logic [3:0] ha,
                           input logic [7:0] hd);
    logic v;
    for (int i = 7; i >= 0; i--) begin
      if (i == hw_bit) host_write(ha, hd);
      read_bit(v);
      b[i] = v;
    end
  endtask

  task automatic compare_strobes(string tag);
    check({tag, " nstrobe"}, 32'(obs_q.size()), 32'(exp_q.size()));
    while (obs_q.size() > 0 && exp_q.size() > 0)
      check({tag, " strobe"}, 32'(obs_q.pop_front()), 32'(exp_q.pop_front()));
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic xfer_write(logic [7:0] regaddr, int n, int col_idx, string tag);
    col_en = 1'b0;
    i2c_start();
    check({tag, " busy_start"}, 32'(bus.busy), 32'd1);
    write_byte(8'h88, 1'b0, {tag, " dev"});
    write_byte(regaddr, 1'b0, {tag, " reg"});
    m_ptr = int'(regaddr[3:0]);
    for (int i = 0; i < n; i++) begin
      col_en = (i == col_idx);
      if (col_en && col_addr != 4'(m_ptr)) m_regs[col_addr] = col_data;
      m_regs[m_ptr] = wbuf[i];
      exp_q.push_back({4'(m_ptr), wbuf[i]});
      m_ptr = (m_ptr + 1) % 16;
      write_byte(wbuf[i], 1'b0, {tag, " data"});
    end
    col_en = 1'b0;
    i2c_stop();
    check({tag, " busy_stop"}, 32'(bus.busy), 32'd0);
    compare_strobes(tag);
  endtask

  task automatic xfer_read(logic set_ptr, logic [7:0] regaddr, int n, int hw_byte, string tag);
    logic [7:0] b;
    logic [7:0] e;
    i2c_start();
    if (set_ptr) begin
      write_byte(8'h88, 1'b0, {tag, " dev_w"});
      write_byte(regaddr, 1'b0, {tag, " reg"});
      m_ptr = int'(regaddr[3:0]);
      i2c_restart();
    end
    write_byte(8'h89, 1'b0, {tag, " dev_r"});
    for (int i = 0; i < n; i++) begin
      e = m_regs[m_ptr];
      if (i == hw_byte) read_byte(b, 3, 4'(m_ptr), ~e);
      else              read_byte(b, -1, 4'd0, 8'h00);
      check({tag, " rdata"}, 32'(b), 32'(e));
      m_ptr = (m_ptr + 1) % 16;
      write_bit(i == n - 1);
    end
    check({tag, " released_after_nack"}, 32'(bus.sda_drive_low), 32'd0);
    i2c_stop();
    check({tag, " busy_stop"}, 32'(bus.busy), 32'd0);
    compare_strobes(tag);
  endtask

  task automatic xfer_bad(logic [6:0] a, logic rw, string tag);
    int d0;
    d0 = drive_cycles;
    i2c_start();
    write_byte({a, rw}, 1'b1, {tag, " dev_nack"});
    write_byte(8'($urandom), 1'b1, {tag, " data_nack"});
    check({tag, " busy_mid"}, 32'(bus.busy), 32'd1);
    i2c_stop();
    check({tag, " busy_stop"}, 32'(bus.busy), 32'd0);
    check({tag, " drive_cycles"}, 32'(drive_cycles - d0), 32'd0);
    compare_strobes(tag);
  endtask

  initial begin
    int n;
    int ci;
    logic [6:0] ba;
    bus.scl = 1'b1; sda_m = 1'b1;
    bus.host_we = 1'b0; bus.host_addr = 4'd0; bus.host_wdata = 8'h00;
    col_en = 1'b0; col_addr = 4'd0; col_data = 8'h00;
    for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
    m_ptr = 0;
    reset_n = 1'b0;
    clk(3);
    check("rst sda_drive_low", 32'(bus.sda_drive_low), 32'd0);
    check("rst wr_strobe", 32'(bus.wr_strobe), 32'd0);
    check("rst wr_addr", 32'(bus.wr_addr), 32'd0);
    check("rst wr_data", 32'(bus.wr_data), 32'd0);
    check("rst busy", 32'(bus.busy), 32'd0);
    reset_n = 1'b1;
    clk(5);

    wbuf[0] = 8'h05;
    xfer_write(8'h01, 1, -1, "wr_reg1");
    xfer_read(1'b1, 8'h01, 1, -1, "rd_reg1");

    for (int i = 0; i < 6; i++) host_write(4'(9 + i), 8'(8'h11 * (i + 1)));
    xfer_read(1'b1, 8'h09, 6, -1, "rd_9_14");

    xfer_bad(7'h45, 1'b0, "bad_45");
    xfer_read(1'b0, 8'h00, 2, -1, "rd_noptr");

    wbuf[0] = 8'hAA; wbuf[1] = 8'hBB;
    xfer_write(8'h0F, 2, -1, "wr_wrap");
    xfer_read(1'b1, 8'h0F, 2, -1, "rd_wrap");

    col_addr = 4'd2; col_data = 8'hEE; wbuf[0] = 8'h77;
    xfer_write(8'h02, 1, 0, "col_same");
    col_addr = 4'd5; col_data = 8'h5A; wbuf[0] = 8'h66;
    xfer_write(8'h06, 1, 0, "col_diff");
    xfer_read(1'b1, 8'h02, 5, -1, "rd_col");

    host_write(4'd4, 8'h3C);
    xfer_read(1'b1, 8'h04, 2, 0, "snap");
    xfer_read(1'b1, 8'h04, 1, -1, "snap_after");

    for (int it = 0; it < 24; it++) begin
      case ($urandom_range(0, 4))
        0: host_write(4'($urandom_range(0, 15)), 8'($urandom));
        1: begin
          n = int'($urandom_range(1, 4));
          for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
          ci = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, n - 1)) : -1;
          col_addr = 4'($urandom_range(0, 15));
          col_data = 8'($urandom);
          xfer_write(8'($urandom), n, ci, "rnd_wr");
        end
        2: xfer_read(1'b1, 8'($urandom), int'($urandom_range(1, 4)), -1, "rnd_rd");
        3: xfer_read(1'b0, 8'h00, int'($urandom_range(1, 4)), int'($urandom_range(0, 3)),
                     "rnd_rd_noptr");
        default: begin
          ba = 7'($urandom_range(0, 127));
          if (ba == 7'h44) ba = 7'h45;
          xfer_bad(ba, 1'($urandom_range(0, 1)), "rnd_bad");
        end
      endcase
    end

    // reset while the target is driving a 0 data bit
    host_write(4'd3, 8'h12);
    i2c_start();
    write_byte(8'h88, 1'b0, "mid_rst dev_w");
    write_byte(8'h03, 1'b0, "mid_rst reg");
    i2c_restart();
    write_byte(8'h89, 1'b0, "mid_rst dev_r");
    check("mid_rst driving", 32'(bus.sda_drive_low), 32'd1);
    reset_n = 1'b0;
    clk(1);
    check("mid_rst released", 32'(bus.sda_drive_low), 32'd0);
    check("mid_rst busy", 32'(bus.busy), 32'd0);
    bus.scl = 1'b1; sda_m = 1'b1;
    clk(3);
    reset_n = 1'b1;
    clk(5);
    for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
    m_ptr = 0;
    obs_q.delete();
    xfer_read(1'b0, 8'h00, 1, -1, "post_rst ptr0");
    xfer_read(1'b1, 8'h00, 16, -1, "post_rst regs");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
